serial_tx_uart: RTL and testbench

Transmit-side serial peripheral on the processor's serial write interface. Accepts bytes from the processor's `serial_out`/`serial_wren_out` port, buffers them in a small FIFO, and drives the processor's `serial_ready_in` as back-pressure. Shifts each byte out on a single UART line as 8N1 (1 start bit, 8 data bits LSB first, 1 stop bit). Sits between the processor core and the board TX pin.

---
 rtl/serial_tx_uart.sv | 156 +++++++++++++++
 tb/tb_serial_tx_uart.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_uart.sv
`default_nettype none
// ============================================================================
// serial_tx_uart : byte FIFO + 8N1 UART transmitter with back-pressure
// Revision 1.0
// ============================================================================
module serial_tx_uart #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] wr_data,
   input  logic       wr_en,
   output logic       ready_out,
   output logic       tx_out,
   output logic       busy_out,
   output logic       overflow_out
);

   localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [c_PTR_W:0]   c_DEPTH    = (c_PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t               r_state;
   logic [7:0]           r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_PTR_W:0]     r_count;
   logic [7:0]           r_shift;
   logic [2:0]           r_bit_idx;
   logic [c_CNT_W-1:0]   r_clk_cnt;
   logic                 r_tx;
   logic                 r_overflow;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_empty;
   logic                 w_bit_end;
   logic [7:0]           w_head;

   assign w_empty   = (r_count == '0);
   assign ready_out = (r_count < c_DEPTH);
   assign w_push    = wr_en && ready_out;
   assign w_bit_end = (r_clk_cnt == c_BIT_LAST);
   assign w_head    = r_mem[r_rd_ptr];
   // Pops happen only from IDLE or on the last stop-bit cycle, so frames chain without a gap.
   assign w_pop     = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

   assign busy_out     = (r_state != S_IDLE) || !w_empty;
   assign tx_out       = r_tx;
   assign overflow_out = r_overflow;

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (wr_en && !ready_out) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_clk_cnt <= '0;
         r_tx      <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx      <= 1'b1;
               r_clk_cnt <= '0;
               if (w_pop) begin
                  r_shift   <= w_head;
                  r_bit_idx <= '0;
                  r_tx      <= 1'b0;
                  r_state   <= S_START;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  r_bit_idx <= '0;
                  r_tx      <= r_shift[0];
                  r_state   <= S_DATA;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  r_shift   <= {1'b0, r_shift[7:1]};
                  if (r_bit_idx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_tx      <= r_shift[1];
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  if (w_pop) begin
                     r_shift   <= w_head;
                     r_bit_idx <= '0;
                     r_tx      <= 1'b0;
                     r_state   <= S_START;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_uart.sv
`default_nettype none
// ============================================================================
// tb_serial_tx_uart : directed bench, line decoder checks bytes and frame timing
// Revision 1.0
// ============================================================================
module tb_serial_tx_uart;

   logic       clock;
   logic       reset;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       ready_out;
   logic       tx_out;
   logic       busy_out;
   logic       overflow_out;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   serial_tx_uart #(
      .CLKS_PER_BIT (4),
      .FIFO_DEPTH   (4)
   ) u_dut (
      .clock        (clock),
      .reset        (reset),
      .wr_data      (wr_data),
      .wr_en        (wr_en),
      .ready_out    (ready_out),
      .tx_out       (tx_out),
      .busy_out     (busy_out),
      .overflow_out (overflow_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Line decoder: offset 0 is the first low negedge; bits sampled mid-period.
   logic       rx_active = 1'b0;
   int         rx_t      = 0;
   int         rx_start  = 0;
   logic       rx_st_ok  = 1'b0;
   logic [7:0] rx_sh     = '0;
   int         rx_err    = 0;
   logic [7:0] rx_q [$];
   int         st_q [$];

   always @(negedge clock) begin
      if (!reset) begin
         rx_active <= 1'b0;
      end else if (!rx_active) begin
         if (tx_out == 1'b0) begin
            rx_active <= 1'b1;
            rx_t      <= 1;
            rx_start  <= cyc;
         end
      end else begin
         rx_t <= rx_t + 1;
         if (rx_t == 2) rx_st_ok <= (tx_out == 1'b0);
         if (rx_t >= 6 && rx_t <= 34 && (rx_t % 4) == 2) rx_sh[(rx_t - 6) / 4] <= tx_out;
         if (rx_t == 38) begin
            if (tx_out !== 1'b1 || !rx_st_ok) rx_err <= rx_err + 1;
            rx_q.push_back(rx_sh);
            st_q.push_back(rx_start);
            rx_active <= 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rx_at(input int i);
      return (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hFFFF_FFFF;
   endfunction

   function automatic int st_at(input int i);
      return (i < st_q.size()) ? st_q[i] : -1000;
   endfunction

   task automatic send(input logic [7:0] b);
      wr_data = b;
      wr_en   = 1'b1;
      @(negedge clock);
      wr_en   = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy_out && n < 1000) begin
         @(negedge clock);
         n++;
      end
      check("idle_timeout", (n < 1000), 1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic clear_rx();
      rx_q.delete();
      st_q.delete();
   endtask

   int w_cyc;
   int n;
   int w;
   int err0;

   initial begin
      reset   = 1'b0;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      repeat (3) @(negedge clock);
      check("rst_tx",    tx_out,       1);
      check("rst_ready", ready_out,    1);
      check("rst_busy",  busy_out,     0);
      check("rst_ovf",   overflow_out, 0);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // single byte: start after edge k+1, busy drops 41 edges after the write
      clear_rx();
      err0 = rx_err;
      send(8'h41);
      w_cyc = cyc;
      wait_idle(n);
      check("s1_busy_len",  n, 41);
      check("s1_nframes",   rx_q.size(), 1);
      check("s1_byte",      rx_at(0), 32'h41);
      check("s1_latency",   st_at(0) - w_cyc, 1);
      check("s1_frame_err", rx_err - err0, 0);

      // three back-to-back frames
      repeat (3) @(negedge clock);
      clear_rx();
      err0 = rx_err;
      send(8'h55);
      send(8'hAA);
      send(8'h0F);
      wait_idle(n);
      check("s2_nframes", rx_q.size(), 3);
      check("s2_byte0",   rx_at(0), 32'h55);
      check("s2_byte1",   rx_at(1), 32'hAA);
      check("s2_byte2",   rx_at(2), 32'h0F);
      check("s2_gap01",   st_at(1) - st_at(0), 40);
      check("s2_gap12",   st_at(2) - st_at(1), 40);
      check("s2_ovf",     overflow_out, 0);
      check("s2_frame_err", rx_err - err0, 0);

      // overflow: sixth write is dropped
      repeat (3) @(negedge clock);
      clear_rx();
      err0 = rx_err;
      for (int i = 0; i < 6; i++) begin
         send(8'(i + 1));
         if (i == 3) check("s3_ready_after4", ready_out, 1);
         if (i == 4) check("s3_ready_after5", ready_out, 0);
         if (i == 4) check("s3_ovf_after5",   overflow_out, 0);
      end
      check("s3_ovf_set", overflow_out, 1);
      wait_idle(n);
      check("s3_nframes", rx_q.size(), 5);
      for (int i = 0; i < 5; i++) check("s3_byte", rx_at(i), 32'(i + 1));
      check("s3_ovf_sticky", overflow_out, 1);
      check("s3_frame_err", rx_err - err0, 0);

      do_reset();
      check("s4_ovf_cleared", overflow_out, 0);

      // keep FIFO full, refill each time ready rises
      clear_rx();
      err0 = rx_err;
      for (int j = 0; j < 5; j++) send(8'(8'h10 + j));
      check("s4_full", ready_out, 0);
      for (int j = 5; j < 12; j++) begin
         w = 0;
         while (!ready_out && w < 100) begin
            @(negedge clock);
            w++;
         end
         check("s4_ready_rise", (w < 100), 1);
         send(8'(8'h10 + j));
         check("s4_refull", ready_out, 0);
      end
      check("s4_ovf", overflow_out, 0);
      wait_idle(n);
      check("s4_nframes", rx_q.size(), 12);
      for (int j = 0; j < 12; j++) check("s4_byte", rx_at(j), 32'(8'h10 + j));
      check("s4_frame_err", rx_err - err0, 0);

      // asynchronous reset in the middle of a data bit
      repeat (3) @(negedge clock);
      send(8'hC3);
      repeat (12) @(negedge clock);
      check("s5_busy_pre", busy_out, 1);
      #2 reset = 1'b0;
      #1;
      check("s5_rst_tx",    tx_out,    1);
      check("s5_rst_ready", ready_out, 1);
      check("s5_rst_busy",  busy_out,  0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      clear_rx();
      err0 = rx_err;
      send(8'h7E);
      w_cyc = cyc;
      wait_idle(n);
      check("s5_busy_len",  n, 41);
      check("s5_nframes",   rx_q.size(), 1);
      check("s5_byte",      rx_at(0), 32'h7E);
      check("s5_latency",   st_at(0) - w_cyc, 1);
      check("s5_frame_err", rx_err - err0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, tests run %0d", n_tests);
      $fatal(1);
   end

endmodule
`default_nettype wire
